// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-side SRAM responder: access-size encodings,
// response payload width and the read-tag pipeline entry.
package data_sram_responder_pkg;

   // data_size encodings (carried for visibility only; the RAM is word wide)
   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;

   // Width of one queued response word
   localparam int RESP_W = 32;

   // One in-flight RAM access waiting for its read data
   typedef struct packed {
      logic valid;
      logic wr;
   } tag_t;

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// resp_fifo: synchronous FIFO with a registered head word and registered
// empty/full flags, so consumers see outputs straight from flops.
// Push and pop may occur in the same cycle; a push into an empty FIFO becomes
// visible on the following cycle (no fall-through).
module resp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] rd_inc;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             pop;

   assign pop    = pop_i && !empty_q;
   assign rd_inc = rd_ptr_q + 1'b1;

   // Next pointers, occupancy, flags and the word that becomes the new head
   always_comb begin
      wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_inc : rd_ptr_q;
      count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop);
      head_d   = head_q;
      if (pop) begin
         if (count_q > CNT_W'(1))
            head_d = mem_q[rd_inc];
         else if (push_i)
            head_d = push_data_i;
         else
            head_d = '0;
      end else if (empty_q && push_i) begin
         head_d = push_data_i;
      end
      empty_d = (count_d == '0);
      full_d  = (count_d == CNT_W'(DEPTH));
   end

   // Control state and head register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

   // Payload storage; contents are don't-care until pushed, so no reset
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = head_q;
   assign empty_o = empty_q;
   assign full_o  = full_q;

   // The outstanding-request limit upstream must keep the FIFO from overflowing
   assert property (@(posedge clk) disable iff (!resetn) !(push_i && full_q));

endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: responder end of the CPU data-side SRAM-like bus,
// backed by an external synchronous single-port RAM with RD_LAT read latency.
// Build option: define DRESP_RAND_STALL_EN to add LFSR-driven random stalls on
// request acceptance and on response delivery.
//
// Handshake: a request transfers in any cycle where data_req && data_addr_ok
// are both high; data_addr_ok does not depend on data_req. Every transfer gets
// exactly one single-cycle data_ok pulse later, in transfer order, and the
// requester must take it (no back-pressure on responses).
module data_sram_responder
   import data_sram_responder_pkg::*;
#(
   parameter int          ADDR_W    = 14,
   parameter int          RD_LAT    = 1,
   parameter int          MAX_OUT   = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [3:0]        data_wstrb,
   input  logic [31:0]       data_addr,
   input  logic [2:0]        data_size,
   input  logic [31:0]       data_wdata,
   output logic              data_addr_ok,
   output logic              data_ok,
   output logic [31:0]       data_rdata,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam int CNT_W = $clog2(MAX_OUT) + 1;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   tag_t              pipe_q [RD_LAT];
   logic              acc;
   logic              addr_gate;
   logic              resp_stall;
   logic              push;
   logic [RESP_W-1:0] push_data;
   logic              fifo_empty;
   logic              unused_full;
   logic              unused_bits;

`ifdef DRESP_RAND_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11, free-running
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // LFSR state register
   always_ff @(posedge clk) begin
      if (!resetn) lfsr_q <= LFSR_SEED;
      else         lfsr_q <= lfsr_d;
   end

   assign addr_gate  = (lfsr_q[1:0] != 2'b00);
   assign resp_stall = (lfsr_q[3:2] == 2'b00);
`else
   logic [15:0] unused_seed;
   assign unused_seed = LFSR_SEED;
   assign addr_gate   = 1'b1;
   assign resp_stall  = 1'b0;
`endif

   // Size and the sub-word/aliased address bits carry no meaning for a word RAM
   assign unused_bits = ^{data_size, data_addr[1:0], data_addr[31:ADDR_W+2]};

   assign data_addr_ok = (cnt_q < CNT_W'(MAX_OUT)) && addr_gate;
   // Reset forces no acceptance so the RAM is never touched while in reset
   assign acc          = data_req && data_addr_ok && resetn;

   assign ram_en    = acc;
   assign ram_we    = (acc && data_wr) ? data_wstrb : 4'b0000;
   assign ram_addr  = data_addr[ADDR_W+1:2];
   assign ram_wdata = data_wdata;

   // Tag pipeline tracks each access until its RAM read data is valid
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= '{valid: acc, wr: data_wr};
         for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign push      = pipe_q[RD_LAT-1].valid;
   assign push_data = pipe_q[RD_LAT-1].wr ? '0 : ram_rdata;

   resp_fifo #(
      .DEPTH (MAX_OUT),
      .WIDTH (RESP_W)
   ) u_resp_fifo (
      .clk         (clk),
      .resetn      (resetn),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (data_ok),
      .head_o      (data_rdata),
      .empty_o     (fifo_empty),
      .full_o      (unused_full)
   );

   assign data_ok = !fifo_empty && !resp_stall;

   // Outstanding count: accepted requests whose data_ok has not yet fired
   always_comb begin
      cnt_d = cnt_q + CNT_W'(acc) - CNT_W'(data_ok);
   end

   // Outstanding count register
   always_ff @(posedge clk) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: two instances share one request stream,
// u_dut1 (RD_LAT=1, MAX_OUT=4) and u_dut2 (RD_LAT=2, MAX_OUT=2), each with its
// own RAM model and shadow-memory scoreboard.
module tb_data_sram_responder;

  localparam int AW = 14;

  logic clk = 1'b0;
  logic resetn;
  logic data_req, data_wr;
  logic [3:0] data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic [2:0] data_size;

  logic aok1, ok1, ram_en1;
  logic [31:0] rdata1, ram_wdata1, ram_rdata1;
  logic [3:0] ram_we1;
  logic [AW-1:0] ram_addr1;
  logic aok2, ok2, ram_en2;
  logic [31:0] rdata2, ram_wdata2, ram_rdata2;
  logic [3:0] ram_we2;
  logic [AW-1:0] ram_addr2;

  logic [31:0] ram1 [0:(1<<AW)-1];
  logic [31:0] ram2 [0:(1<<AW)-1];
  logic [31:0] sh1 [0:(1<<AW)-1];
  logic [31:0] sh2 [0:(1<<AW)-1];
  logic [31:0] rd1_0, rd2_0, rd2_1;

  logic [31:0] exp_q[$];
  logic [31:0] exp2_q[$];
  int exp_cyc_q[$];
  logic [31:0] rsp_q[$];
  int rsp_cyc_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cnt1 = 0, cnt2 = 0;
  int ok_tot1 = 0, acc_tot2 = 0, ok_tot2 = 0, aok_low2 = 0;
  int aok_stall = 0, ok_stall = 0;
  logic acc1, acc2;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  data_sram_responder #(.ADDR_W(AW), .RD_LAT(1), .MAX_OUT(4)) u_dut1 (
    .clk(clk), .resetn(resetn), .data_req(data_req), .data_wr(data_wr),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_size(data_size),
    .data_wdata(data_wdata), .data_addr_ok(aok1), .data_ok(ok1),
    .data_rdata(rdata1), .ram_en(ram_en1), .ram_we(ram_we1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1));

  data_sram_responder #(.ADDR_W(AW), .RD_LAT(2), .MAX_OUT(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .data_req(data_req), .data_wr(data_wr),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_size(data_size),
    .data_wdata(data_wdata), .data_addr_ok(aok2), .data_ok(ok2),
    .data_rdata(rdata2), .ram_en(ram_en2), .ram_we(ram_we2),
    .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2));

  // ---------------- RAM models ----------------
  always @(posedge clk) begin
    if (ram_en1) begin
      rd1_0 <= ram1[ram_addr1];
      for (int b = 0; b < 4; b++)
        if (ram_we1[b]) ram1[ram_addr1][8*b +: 8] <= ram_wdata1[8*b +: 8];
    end
  end
  assign ram_rdata1 = rd1_0;

  always @(posedge clk) begin
    if (ram_en2) begin
      rd2_0 <= ram2[ram_addr2];
      for (int b = 0; b < 4; b++)
        if (ram_we2[b]) ram2[ram_addr2][8*b +: 8] <= ram_wdata2[8*b +: 8];
    end
    rd2_1 <= rd2_0;
  end
  assign ram_rdata2 = rd2_1;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // ---------------- scoreboard, instance 1 ----------------
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_ram_en1", {31'd0, ram_en1}, 32'd0);
      exp_q.delete();
      exp_cyc_q.delete();
      cnt1 = 0;
    end else begin
      acc1 = data_req && aok1;
`ifdef DRESP_RAND_STALL_EN
      if (aok1) chk("aok1_bound", {31'd0, cnt1 < 4}, 32'd1);
      if (data_req && !aok1) aok_stall++;
      if (!ok1 && exp_q.size() != 0 && cyc >= exp_cyc_q[0] + 2) ok_stall++;
`else
      chk("aok1", {31'd0, aok1}, {31'd0, cnt1 < 4});
`endif
      chk("ram_en1", {31'd0, ram_en1}, {31'd0, acc1});
      chk("ram_we1", {28'd0, ram_we1}, {28'd0, (acc1 && data_wr) ? data_wstrb : 4'h0});
      if (acc1) chk("ram_addr1", {18'd0, ram_addr1}, {18'd0, data_addr[AW+1:2]});
      if (ok1) begin
        ok_tot1++;
        rsp_q.push_back(rdata1);
        rsp_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) chk("ok1_unexpected", 32'd1, 32'd0);
        else begin
          chk("rsp1", rdata1, exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end
      if (acc1) begin
        if (data_wr) begin
          sh1[data_addr[AW+1:2]] = merge(sh1[data_addr[AW+1:2]], data_wdata, data_wstrb);
          exp_q.push_back(32'd0);
        end else begin
          exp_q.push_back(sh1[data_addr[AW+1:2]]);
        end
        exp_cyc_q.push_back(cyc);
      end
      cnt1 = cnt1 + int'(acc1) - int'(ok1);
    end
  end

  // ---------------- scoreboard, instance 2 ----------------
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_ram_en2", {31'd0, ram_en2}, 32'd0);
      exp2_q.delete();
      cnt2 = 0;
    end else begin
      acc2 = data_req && aok2;
`ifdef DRESP_RAND_STALL_EN
      if (aok2) chk("aok2_bound", {31'd0, cnt2 < 2}, 32'd1);
`else
      chk("aok2", {31'd0, aok2}, {31'd0, cnt2 < 2});
`endif
      if (data_req && !aok2) aok_low2++;
      if (ok2) begin
        ok_tot2++;
        if (exp2_q.size() == 0) chk("ok2_unexpected", 32'd1, 32'd0);
        else chk("rsp2", rdata2, exp2_q.pop_front());
      end
      if (acc2) begin
        acc_tot2++;
        if (data_wr) begin
          sh2[data_addr[AW+1:2]] = merge(sh2[data_addr[AW+1:2]], data_wdata, data_wstrb);
          exp2_q.push_back(32'd0);
        end else begin
          exp2_q.push_back(sh2[data_addr[AW+1:2]]);
        end
      end
      cnt2 = cnt2 + int'(acc2) - int'(ok2);
    end
  end

  // ---------------- driver tasks ----------------
  // Present one request and hold it until instance 1 accepts it (bounded).
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd);
    logic accepted;
    int waited;
    accepted = 1'b0;
    waited = 0;
    data_req = 1'b1;
    data_wr = wr;
    data_addr = addr;
    data_wstrb = strb;
    data_wdata = wd;
    data_size = 3'd2;
    while (!accepted) begin
      @(negedge clk);
      accepted = aok1;
      @(posedge clk);
      #2;
      if (!accepted) begin
        waited++;
        if (waited > 50) begin
          chk("req_timeout", 32'd0, 32'd1);
          accepted = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    data_req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain;
    int w;
    w = 0;
    data_req = 1'b0;
    while ((cnt1 != 0 || cnt2 != 0) && w < 200) begin
      @(posedge clk);
      #2;
      w++;
    end
    chk("drain", {31'd0, cnt1 == 0 && cnt2 == 0}, 32'd1);
    idle(2);
  endtask

  task automatic preload(input int word, input logic [31:0] val);
    ram1[word] <= val;
    ram2[word] <= val;
    sh1[word] = val;
    sh2[word] = val;
  endtask

  // ---------------- stimulus ----------------
  int t0, ok_snap, acc2_snap, ok2_snap, low2_snap, n_rand;
  logic [31:0] ra, rw;

  initial begin
    resetn = 1'b0;
    data_req = 1'b0;
    data_wr = 1'b0;
    data_wstrb = 4'h0;
    data_addr = 32'h0;
    data_wdata = 32'h0;
    data_size = 3'd2;
    for (int i = 0; i < (1 << AW); i++) preload(i, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b1;

    // reset state
    @(negedge clk);
    chk("reset_aok1", {31'd0, aok1}, 32'd1);
    chk("reset_ok1", {31'd0, ok1}, 32'd0);
    chk("reset_rdata1", rdata1, 32'd0);
    chk("reset_aok2", {31'd0, aok2}, 32'd1);
    chk("reset_rdata2", rdata2, 32'd0);
    @(posedge clk);
    #2;

    // write then read back-to-back at 0x100
    rsp_q.delete();
    rsp_cyc_q.delete();
    t0 = cyc;
    do_req(1'b1, 32'h0000_0100, 4'hF, 32'hDEADBEEF);
    do_req(1'b0, 32'h0000_0100, 4'h0, 32'h0);
    drain();
    chk("t1_count", rsp_q.size(), 32'd2);
    chk("t1_wr_rsp", rsp_q[0], 32'd0);
    chk("t1_rd_rsp", rsp_q[1], 32'hDEADBEEF);
`ifndef DRESP_RAND_STALL_EN
    chk("t1_latency", rsp_cyc_q[0] - t0, 32'd2);
`endif

    // partial write into a preloaded word
    preload(32'h80, 32'h11223344);
    idle(1);
    rsp_q.delete();
    do_req(1'b1, 32'h0000_0200, 4'b0100, 32'h00AB0000);
    do_req(1'b0, 32'h0000_0200, 4'h0, 32'h0);
    drain();
    chk("t2_count", rsp_q.size(), 32'd2);
    chk("t2_wr_rsp", rsp_q[0], 32'd0);
    chk("t2_rd_rsp", rsp_q[1], 32'h11AB3344);

    // ten back-to-back reads of preloaded words 0..9
    for (int i = 0; i < 10; i++) preload(i, 32'(i * 3));
    idle(1);
    rsp_q.delete();
    rsp_cyc_q.delete();
    acc2_snap = acc_tot2;
    ok2_snap = ok_tot2;
    low2_snap = aok_low2;
    t0 = cyc;
    for (int i = 0; i < 10; i++) do_req(1'b0, 32'(i * 4), 4'h0, 32'h0);
`ifndef DRESP_RAND_STALL_EN
    chk("t3_no_stall", cyc - t0, 32'd10);
`endif
    drain();
    chk("t3_count", rsp_q.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk("t3_data", rsp_q[i], 32'(i * 3));
`ifndef DRESP_RAND_STALL_EN
      chk("t3_cycle", rsp_cyc_q[i] - t0, 32'(i + 2));
`endif
    end
    chk("t3_dut2_balance", acc_tot2 - acc2_snap, ok_tot2 - ok2_snap);

    // instance 2 under continuous requests: 2 accepted per 4 cycles
    acc2_snap = acc_tot2;
    ok2_snap = ok_tot2;
    low2_snap = aok_low2;
    data_req = 1'b1;
    data_wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      data_addr = 32'((i % 10) * 4);
      @(posedge clk);
      #2;
    end
    drain();
    chk("t4_balance", acc_tot2 - acc2_snap, ok_tot2 - ok2_snap);
`ifndef DRESP_RAND_STALL_EN
    chk("t4_accepted", acc_tot2 - acc2_snap, 32'd8);
    chk("t4_aok_low", aok_low2 - low2_snap, 32'd8);
`else
    chk("t4_aok_low_seen", {31'd0, aok_low2 > low2_snap}, 32'd1);
`endif

    // reset with reads in flight
    do_req(1'b0, 32'h0000_0100, 4'h0, 32'h0);
    do_req(1'b0, 32'h0000_0100, 4'h0, 32'h0);
    do_req(1'b0, 32'h0000_0100, 4'h0, 32'h0);
    resetn = 1'b0;
    data_req = 1'b1;
    @(posedge clk);
    #2;
    resetn = 1'b1;
    data_req = 1'b0;
    @(negedge clk);
    chk("t5_aok1", {31'd0, aok1}, 32'd1);
    chk("t5_ok1", {31'd0, ok1}, 32'd0);
    chk("t5_rdata1", rdata1, 32'd0);
    chk("t5_aok2", {31'd0, aok2}, 32'd1);
    ok_snap = ok_tot1;
    ok2_snap = ok_tot2;
    @(posedge clk);
    #2;
    idle(10);
    chk("t5_no_ok1", ok_tot1 - ok_snap, 32'd0);
    chk("t5_no_ok2", ok_tot2 - ok2_snap, 32'd0);
    rsp_q.delete();
    do_req(1'b0, 32'h0000_0100, 4'h0, 32'h0);
    drain();
    chk("t5_ram_kept", rsp_q[0], 32'hDEADBEEF);

    // random mixed traffic against the shadow memories
`ifdef DRESP_RAND_STALL_EN
    n_rand = 1000;
`else
    n_rand = 300;
`endif
    for (int i = 0; i < n_rand; i++) begin
      ra = (32'($urandom_range(0, 255)) << 16) | (32'($urandom_range(0, 63)) << 2);
      rw = $urandom;
      do_req(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), rw);
      if ($urandom_range(0, 5) == 0) idle(1);
    end
    drain();
`ifdef DRESP_RAND_STALL_EN
    chk("addr_ok_stalls", {31'd0, aok_stall >= 100}, 32'd1);
    chk("data_ok_stalls", {31'd0, ok_stall >= 100}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
